// File: rtl/mm_pkg.sv
// mm_pkg: shared constants and types for the matrix-multiply sequencer.
//   MM_MATRIX_SIZE : default N (power of two, >= 2)
//   MM_DATA_W      : width of a dot-product result (adder-tree output)
//   MM_IDX_W       : row/column index width
//   MM_MEM_LAT     : A/B memory read latency
//   MM_PIPE_LAT    : datapath latency (1 multiply + log2(N) adder levels)
//   MM_TAG_DEPTH   : total issue-to-write latency tracked by the tag pipe
package mm_pkg;

  localparam int MM_MATRIX_SIZE = 4;
  localparam int MM_DATA_W      = 16;
  localparam int MM_IDX_W       = $clog2(MM_MATRIX_SIZE);
  localparam int MM_MEM_LAT     = 1;
  localparam int MM_PIPE_LAT    = 1 + $clog2(MM_MATRIX_SIZE);
  localparam int MM_TAG_DEPTH   = MM_MEM_LAT + MM_PIPE_LAT;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mm_state_t;

  // Tag carried alongside each issued dot product (default-size layout).
  typedef struct packed {
    logic                valid;
    logic [MM_IDX_W-1:0] i;
    logic [MM_IDX_W-1:0] j;
  } mm_tag_t;

endpackage

// File: rtl/mm_tag_pipe.sv
// mm_tag_pipe: depth-DEPTH shift register of issue tags.
//   clk, rstb : clock, asynchronous active-low clear of every stage
//   tag_in    : tag entering stage 0 (MSB is the valid bit)
//   tag_out   : tag leaving the last stage (drives the C write)
//   any_valid : a valid tag sits in any stage ahead of the output stage,
//               i.e. a write is still owed after the current cycle
module mm_tag_pipe
  import mm_pkg::*;
#(
  parameter int DEPTH = MM_TAG_DEPTH,
  parameter int TAG_W = 1 + 2 * MM_IDX_W
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic [TAG_W-1:0] tag_in,
  output logic [TAG_W-1:0] tag_out,
  output logic             any_valid
);

  logic [TAG_W-1:0] stage_reg [DEPTH];
  logic [DEPTH-1:0] valid_vec;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int s = 0; s < DEPTH; s++) stage_reg[s] <= '0;
    end else begin
      stage_reg[0] <= tag_in;
      for (int s = 1; s < DEPTH; s++) stage_reg[s] <= stage_reg[s-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_valid
      assign valid_vec[gi] = stage_reg[gi][TAG_W-1];
    end
  endgenerate

  // The output stage is excluded: when only it holds a valid tag, the final
  // write happens this cycle and the sequencer may leave DRAIN right away.
  localparam logic [DEPTH-1:0] IN_FLIGHT_MASK = ~(DEPTH'(1) << (DEPTH - 1));

  assign any_valid = |(valid_vec & IN_FLIGHT_MASK);
  assign tag_out   = stage_reg[DEPTH-1];

endmodule

// File: rtl/mm_sequencer.sv
// mm_sequencer: walks all N x N (row, column) pairs of a matrix multiply,
// issuing one A-row / B-column read pair per cycle, and writes each
// dot-product result to C (row-major) once it emerges from the datapath.
//   clk, rstb          : clock, asynchronous active-low reset
//   start              : begin a full multiply (sampled in IDLE only)
//   busy, done         : run in progress / one-cycle completion pulse
//   a_rd_en, a_rd_addr : A-row memory read (row index i)
//   b_rd_en, b_rd_addr : B-column memory read (column index j, B transposed)
//   dp_result          : dot-product datapath output
//   c_wr_en/addr/data  : C write port; data passes straight from dp_result
module mm_sequencer
  import mm_pkg::*;
#(
  parameter int MATRIX_SIZE = MM_MATRIX_SIZE,
  parameter int IDX_W       = $clog2(MATRIX_SIZE),
  parameter int MEM_LAT     = MM_MEM_LAT,
  parameter int PIPE_LAT    = 1 + $clog2(MATRIX_SIZE)
) (
  input  logic                 clk,
  input  logic                 rstb,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 a_rd_en,
  output logic [IDX_W-1:0]     a_rd_addr,
  output logic                 b_rd_en,
  output logic [IDX_W-1:0]     b_rd_addr,
  input  logic [MM_DATA_W-1:0] dp_result,
  output logic                 c_wr_en,
  output logic [2*IDX_W-1:0]   c_wr_addr,
  output logic [MM_DATA_W-1:0] c_wr_data
);

  localparam int                TAG_DEPTH = MEM_LAT + PIPE_LAT;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(MATRIX_SIZE - 1);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] i;
    logic [IDX_W-1:0] j;
  } tag_t;

  mm_state_t        state_reg, state_next;
  logic [IDX_W-1:0] i_reg, i_next;
  logic [IDX_W-1:0] j_reg, j_next;
  logic             issue;
  logic             any_valid;
  tag_t             push_tag;
  tag_t             wr_tag;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_reg <= IDLE;
      i_reg     <= '0;
      j_reg     <= '0;
    end else begin
      state_reg <= state_next;
      i_reg     <= i_next;
      j_reg     <= j_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    i_next     = i_reg;
    j_next     = j_reg;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ISSUE;
          i_next     = '0;
          j_next     = '0;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        // N is a power of two, so the increments wrap to 0 on their own;
        // after the last pair both indices are back at 0.
        j_next = j_reg + IDX_W'(1);
        if (j_reg == LAST_IDX) begin
          i_next = i_reg + IDX_W'(1);
          if (i_reg == LAST_IDX) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!any_valid) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bubbles are all-zero so the write address rests at 0 when idle.
  always_comb begin
    push_tag = '0;
    if (issue) begin
      push_tag.valid = 1'b1;
      push_tag.i     = i_reg;
      push_tag.j     = j_reg;
    end
  end

  mm_tag_pipe #(
    .DEPTH (TAG_DEPTH),
    .TAG_W ($bits(tag_t))
  ) u_tag_pipe (
    .clk       (clk),
    .rstb      (rstb),
    .tag_in    (push_tag),
    .tag_out   (wr_tag),
    .any_valid (any_valid)
  );

  assign busy      = (state_reg != IDLE);
  assign done      = (state_reg == DONE);
  assign a_rd_en   = issue;
  assign b_rd_en   = issue;
  assign a_rd_addr = i_reg;
  assign b_rd_addr = j_reg;
  assign c_wr_en   = wr_tag.valid;
  assign c_wr_addr = {wr_tag.i, wr_tag.j};   // i*N + j for power-of-two N
  assign c_wr_data = dp_result;

endmodule

// File: tb/tb_mm_sequencer.sv
// tb_mm_sequencer: drives mm_sequencer with an A/B memory + datapath
// environment and checks every cycle against a run-timeline reference model.
module tb_mm_sequencer;

  localparam int N       = 4;
  localparam int IW      = 2;
  localparam int D       = 4;              // memory + datapath latency
  localparam int DONE_OFF = N * N + D + 1;  // done cycle offset from start

  logic          clk = 1'b0;
  logic          rstb = 1'b0;
  logic          start = 1'b0;
  logic          busy, done;
  logic          a_rd_en, b_rd_en;
  logic [IW-1:0] a_rd_addr, b_rd_addr;
  logic [15:0]   dp_result;
  logic          c_wr_en;
  logic [2*IW-1:0] c_wr_addr;
  logic [15:0]   c_wr_data;

  mm_sequencer dut (
    .clk       (clk),
    .rstb      (rstb),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .a_rd_en   (a_rd_en),
    .a_rd_addr (a_rd_addr),
    .b_rd_en   (b_rd_en),
    .b_rd_addr (b_rd_addr),
    .dp_result (dp_result),
    .c_wr_en   (c_wr_en),
    .c_wr_addr (c_wr_addr),
    .c_wr_data (c_wr_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // ---------------- environment: A/B memories and datapath ----------------
  logic signed [7:0] a_mem [N][N];
  logic signed [7:0] b_mem [N][N];
  logic [15:0]       dp_pipe [D];

  function automatic logic [15:0] row_dot_col(input int r, input int c);
    int s = 0;
    for (int k = 0; k < N; k++) s += int'(a_mem[r][k]) * int'(b_mem[k][c]);
    return s[15:0];
  endfunction

  always @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      for (int x = 0; x < D; x++) dp_pipe[x] <= 16'h0;
    end else begin
      dp_pipe[0] <= (a_rd_en && b_rd_en) ? row_dot_col(int'(a_rd_addr), int'(b_rd_addr)) : 16'h0;
      for (int x = 1; x < D; x++) dp_pipe[x] <= dp_pipe[x-1];
    end
  end
  assign dp_result = dp_pipe[D-1];

  // ---------------- reference model ----------------
  // A run started in cycle t issues k in t+1+k, writes k in t+1+k+D,
  // pulses done at t+N*N+D+1 and is idle again from the cycle after.
  int          run_start = -1;
  logic [15:0] exp_c [N*N];
  int          n_writes = 0;

  always @(negedge clk) begin : model
    int  off, k, s;
    bit  in_run;
    if (!rstb) begin
      run_start = -1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_a_rd_en", a_rd_en, 0);
      chk("rst_b_rd_en", b_rd_en, 0);
      chk("rst_a_rd_addr", a_rd_addr, 0);
      chk("rst_b_rd_addr", b_rd_addr, 0);
      chk("rst_c_wr_en", c_wr_en, 0);
      chk("rst_c_wr_addr", c_wr_addr, 0);
      chk("rst_c_wr_data", c_wr_data, 0);
    end else begin
      off    = cyc - run_start;
      in_run = (run_start >= 0) && (off >= 1) && (off <= DONE_OFF);
      chk("busy", busy, in_run);
      chk("done", done, in_run && off == DONE_OFF);
      chk("a_rd_en", a_rd_en, in_run && off <= N * N);
      chk("b_rd_en", b_rd_en, in_run && off <= N * N);
      chk("c_wr_en", c_wr_en, in_run && off >= 1 + D && off <= N * N + D);
      if (in_run && off <= N * N) begin
        k = off - 1;
        chk("a_rd_addr", a_rd_addr, k / N);
        chk("b_rd_addr", b_rd_addr, k % N);
      end
      if (in_run && off >= 1 + D && off <= N * N + D) begin
        k = off - 1 - D;
        chk("c_wr_addr", c_wr_addr, k);
        chk("c_wr_data", c_wr_data, exp_c[k]);
      end
      if (c_wr_en) begin
        n_writes++;
        $display("cycle %0d: C[%0d] <= %04h", cyc, c_wr_addr, c_wr_data);
      end
      if (!in_run && start) begin
        run_start = cyc;
        for (int r = 0; r < N; r++)
          for (int c = 0; c < N; c++) begin
            s = 0;
            for (int m = 0; m < N; m++) s += int'(a_mem[r][m]) * int'(b_mem[m][c]);
            exp_c[r * N + c] = s[15:0];
          end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic load(input int mode);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        case (mode)
          0: begin
            a_mem[r][c] = (r == c) ? 8'sd1 : 8'sd0;
            b_mem[r][c] = 8'(r * N + c);
          end
          1: begin
            a_mem[r][c] = 8'sd127;
            b_mem[r][c] = 8'sd127;
          end
          2: begin
            a_mem[r][c] = 8'h80;
            b_mem[r][c] = 8'h80;
          end
          default: begin
            a_mem[r][c] = 8'($urandom);
            b_mem[r][c] = 8'($urandom);
          end
        endcase
      end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // start high for exactly one cycle; returns one cycle after the start cycle
  task automatic pulse_start();
    cycles(1);
    start = 1'b1;
    cycles(1);
    start = 1'b0;
  endtask

  initial begin : stim
    int w0;
    load(0);
    cycles(3);
    rstb = 1'b1;
    cycles(2);

    // identity A, patterned B
    w0 = n_writes;
    pulse_start();
    cycles(DONE_OFF + 2);
    chk("writes_identity", n_writes - w0, N * N);

    // saturating-looking values that must wrap
    load(1);
    pulse_start();
    cycles(DONE_OFF + 2);
    load(2);
    pulse_start();
    cycles(DONE_OFF + 2);

    // start pulses at t+3 and t+21 are ignored
    load(3);
    w0 = n_writes;
    pulse_start();                 // now in cycle t+1
    cycles(2);  start = 1'b1;      // t+3
    cycles(1);  start = 1'b0;
    cycles(17); start = 1'b1;      // t+21
    cycles(1);  start = 1'b0;
    cycles(4);
    chk("writes_ignored_start", n_writes - w0, N * N);

    // reset mid-run at t+10
    load(3);
    pulse_start();                 // t+1
    cycles(9);
    rstb = 1'b0;                   // t+10
    cycles(2);
    rstb = 1'b1;
    w0 = n_writes;
    cycles(12);
    chk("writes_after_reset", n_writes - w0, 0);
    w0 = n_writes;
    pulse_start();
    cycles(DONE_OFF + 2);
    chk("writes_rerun", n_writes - w0, N * N);

    // back-to-back with start held: runs at t and t+22
    load(3);
    w0 = n_writes;
    cycles(1);
    start = 1'b1;
    cycles(DONE_OFF + 2);
    start = 1'b0;
    cycles(DONE_OFF + 3);
    chk("writes_back_to_back", n_writes - w0, 2 * N * N);

    // randomized runs with random gaps
    for (int r = 0; r < 6; r++) begin
      load(3);
      pulse_start();
      cycles(DONE_OFF + $urandom_range(0, 3));
    end
    cycles(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
